conv3x3_stream: RTL
===================

# conv3x3_stream

Parametrised streaming 3x3 convolution engine; next-generation replacement for the fixed Sobel engine between input BRAM0 and output BRAM1. It reads every input pixel exactly once in raster order, keeps two line buffers plus a 3x3 window, and writes one output pixel per clock in steady state. Supports Sobel magnitude and a runtime-loadable signed kernel with arithmetic shift. Pixel and coefficient widths are configurable.

## Interface
- IMG_WIDTH, 256, pixels per row (>=3)
- IMG_HEIGHT, 256, rows (>=3)
- PIX_W, 8, pixel width; input bram0_dout[PIX_W-1:0], output clipped to [0, 2^PIX_W-1]
- COEF_W, 8, signed kernel coefficient width
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  level; sampled in IDLE to begin a frame
- mode  in  2  0/3 Sobel |Gx|+|Gy|; 1 custom signed clip; 2 custom |.| clip
- shift  in  4  arithmetic right shift for modes 1/2
- kwe  in  1  kernel coefficient write strobe
- kaddr  in  4  coefficient index 0..8 (row-major; 9..15 ignored)
- kdata  in  COEF_W  signed coefficient
- busy  out  1  high in RUN, FLUSH, DRAIN
- done  out  1  high in DONE
- bram0_addr  out  32  byte address (index<<2), registered
- bram0_en  out  1  read enable, registered
- bram0_dout  in  32  read data, valid the cycle after bram0_en is high
- bram1_addr  out  32  byte address (index<<2), registered
- bram1_din  out  32  {zero-ext, result[PIX_W-1:0]}, registered
- bram1_we  out  4  4'b1111 for one cycle per output pixel, else 0

## Operation
- Reset: all outputs 0; state IDLE; kernel = identity (k[4]=1, rest 0); line buffers and window need not be cleared.
- FSM: IDLE -> RUN on start; RUN -> FLUSH after N=W*H reads issued; FLUSH -> DRAIN after W+1 zero slots; DRAIN -> DONE after last write; DONE -> IDLE when start low (held high stays in DONE).
- mode and shift latched on IDLE->RUN; changes mid-frame have no effect. start ignored outside IDLE/DONE.
- Kernel writes accepted only in IDLE (kwe && kaddr<9); ignored in all other states.
- RUN: one read per cycle, index p=0..N-1, bram0_en=1. FLUSH: bram0_en=0, slot injects pixel value 0.
- Slot s (read or flush) completes window centred at c=s-W-1; a write is produced for every c>=0, so exactly N writes, addresses 0..N-1 ascending.
- Window w[0..8] row-major, w[0]=(x-1,y-1). Zero padding: left column zero at x=0, right column zero at x=W-1 (no horizontal wrap), top row zero at y=0, bottom row zero at y=H-1.
- Sobel: Gx=w0-w2+2w3-2w5+w6-w8; Gy=w0+2w1+w2-w6-2w7-w8; result=min(|Gx|+|Gy|, 2^PIX_W-1).
- Custom: S=sum(k[i]*w[i]) signed, ACC_W=PIX_W+COEF_W+4, pixels zero-extended; T=S>>>shift. Mode1: clip T to [0,max]; mode2: clip |T| to max.

## Timing
- Fixed latency: bram1_we for pixel c is high 5 cycles after the edge registering bram0_addr (or flush slot) for slot c+W+1: addr(0), dout(1), window(2), multiply(3), sum/magnitude(4), write regs(5).
- Throughput 1 pixel/clk; no stalls. Frame cycles from start sample to done: N + W + 1 + 5 + 1.
- done rises the cycle after the final bram1_we pulse; busy falls with it.
- bram1_din/addr hold last value when we=0.
- rst_n asserted mid-frame: outputs return to 0 immediately (we=0 asynchronously); next frame requires new start.

## Test plan
- W=4,H=3, mode1, shift0, identity kernel, pixels=index*10 -> BRAM1[i]=i*10 for all 12, writes in order, exactly 12 pulses.
- Constant 100, Sobel -> corners 255, top/bottom edge middle 255, left/right edge (0,1) 255, interior (1,1),(2,1) = 0.
- Kernel all 0xFF, shift 3, constant 80, W=H=4: interior mode2 -> 90, mode1 -> 0; corner (0,0) sum -320 -> mode2 40.
- kwe during RUN (k[4]=0) -> ignored; identity result unchanged; next frame after load in IDLE uses new kernel.
- rst_n low at 7th RUN cycle -> bram1_we=0, busy=0 same cycle; subsequent start completes full frame correctly.
- start held high through DONE -> done stays 1, no second frame; start low -> IDLE, start again -> second frame, identical output.

Source files
------------

// File: rtl/conv3x3_stream_if.sv
// rtl/conv3x3_stream_if.sv - BRAM0 read port and BRAM1 write port bundle for conv3x3_stream
interface conv3x3_stream_if;
  logic [31:0] bram0_addr;
  logic        bram0_en;
  logic [31:0] bram0_dout;
  logic [31:0] bram1_addr;
  logic [31:0] bram1_din;
  logic [3:0]  bram1_we;

  modport master (
    output bram0_addr, bram0_en,
    input  bram0_dout,
    output bram1_addr, bram1_din, bram1_we
  );

  modport slave (
    input  bram0_addr, bram0_en,
    output bram0_dout,
    input  bram1_addr, bram1_din, bram1_we
  );
endinterface

// File: rtl/conv3x3_stream.sv
// rtl/conv3x3_stream.sv - streaming 3x3 convolution (Sobel or loadable signed kernel), BRAM0 -> BRAM1
module conv3x3_stream #(
  parameter int IMG_WIDTH  = 256,
  parameter int IMG_HEIGHT = 256,
  parameter int PIX_W      = 8,
  parameter int COEF_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [3:0]        shift,
  input  logic              kwe,
  input  logic [3:0]        kaddr,
  input  logic [COEF_W-1:0] kdata,
  output logic              busy,
  output logic              done,
  conv3x3_stream_if.master  bus
);
  localparam int N     = IMG_WIDTH * IMG_HEIGHT;
  localparam int ACC_W = PIX_W + COEF_W + 4;
  localparam int XW    = $clog2(IMG_WIDTH);
  localparam int YW    = $clog2(IMG_HEIGHT);
  localparam logic [31:0]   LAST_IDX   = 32'(N - 1);
  localparam logic [31:0]   FLUSH_LAST = 32'(IMG_WIDTH);
  localparam logic [31:0]   FIRST_CTR  = 32'(IMG_WIDTH + 1);
  localparam logic [XW-1:0] X_LAST     = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST     = YW'(IMG_HEIGHT - 1);
  localparam logic signed [ACC_W-1:0] PMAX = ACC_W'((1 << PIX_W) - 1);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_FLUSH, S_DRAIN, S_DONE} state_t;

  state_t                    state;
  logic [1:0]                mode_q;
  logic [3:0]                shift_q;
  logic signed [COEF_W-1:0]  kern [9];
  logic [31:0]               rd_idx, fl_cnt, in_cnt, out_cnt;
  logic                      a_vld, a_flush, b_vld, b_flush, c_vld, d_vld, e_vld, last_wr;
  logic [31:0]               r0_addr, r1_addr, r1_din;
  logic                      r0_en;
  logic [3:0]                r1_we;
  logic [XW-1:0]             xi, ccx, c_x;
  logic [YW-1:0]             ccy, c_y;
  logic [PIX_W-1:0]          lb0 [IMG_WIDTH];
  logic [PIX_W-1:0]          lb1 [IMG_WIDTH];
  logic [PIX_W-1:0]          win [9];
  logic [PIX_W-1:0]          m [9];
  logic [PIX_W-1:0]          in_px, e_res, res;
  logic signed [ACC_W-1:0]   pz [9];
  logic signed [ACC_W-1:0]   prod [9];
  logic signed [ACC_W-1:0]   d_prod [9];
  logic signed [ACC_W-1:0]   gx, gy, d_gx, d_gy, sum, t, ax, ay, mag;
  logic                      start_frame;
  logic                      unused_dout;

  assign bus.bram0_addr = r0_addr;
  assign bus.bram0_en   = r0_en;
  assign bus.bram1_addr = r1_addr;
  assign bus.bram1_din  = r1_din;
  assign bus.bram1_we   = r1_we;
  assign unused_dout    = &{1'b0, bus.bram0_dout[31:PIX_W]};
  assign start_frame    = (state == S_IDLE) && start;
  assign in_px          = b_flush ? '0 : bus.bram0_dout[PIX_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      mode_q  <= '0;
      shift_q <= '0;
      for (int i = 0; i < 9; i++) kern[i] <= '0;
      kern[4] <= COEF_W'(1);
      rd_idx  <= '0;
      fl_cnt  <= '0;
      r0_en   <= 1'b0;
      r0_addr <= '0;
      a_vld   <= 1'b0;
      a_flush <= 1'b0;
    end else begin
      a_vld   <= 1'b0;
      a_flush <= 1'b0;
      r0_en   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (kwe && kaddr < 4'd9) kern[kaddr] <= kdata;
          if (start) begin
            state   <= S_RUN;
            busy    <= 1'b1;
            mode_q  <= mode;
            shift_q <= shift;
            rd_idx  <= '0;
            fl_cnt  <= '0;
          end
        end
        S_RUN: begin
          r0_en   <= 1'b1;
          r0_addr <= rd_idx << 2;
          a_vld   <= 1'b1;
          rd_idx  <= rd_idx + 32'd1;
          if (rd_idx == LAST_IDX) state <= S_FLUSH;
        end
        // Flush slots push zeros through so the last row's windows complete.
        S_FLUSH: begin
          a_vld   <= 1'b1;
          a_flush <= 1'b1;
          fl_cnt  <= fl_cnt + 32'd1;
          if (fl_cnt == FLUSH_LAST) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (last_wr) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          if (!start) begin
            state <= S_IDLE;
            done  <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_vld <= 1'b0; b_flush <= 1'b0; c_vld <= 1'b0; d_vld <= 1'b0; e_vld <= 1'b0;
      in_cnt <= '0; out_cnt <= '0; last_wr <= 1'b0;
      xi <= '0; ccx <= '0; ccy <= '0; c_x <= '0; c_y <= '0;
      r1_addr <= '0; r1_din <= '0; r1_we <= '0;
    end else begin
      if (start_frame) begin
        in_cnt <= '0; out_cnt <= '0; last_wr <= 1'b0;
        xi <= '0; ccx <= '0; ccy <= '0;
      end
      b_vld   <= a_vld;
      b_flush <= a_flush;
      // Slot s completes the window centred on pixel s-W-1.
      c_vld   <= b_vld && (in_cnt >= FIRST_CTR);
      if (b_vld) begin
        in_cnt <= in_cnt + 32'd1;
        xi     <= (xi == X_LAST) ? '0 : xi + 1'b1;
        if (in_cnt >= FIRST_CTR) begin
          c_x <= ccx;
          c_y <= ccy;
          if (ccx == X_LAST) begin
            ccx <= '0;
            ccy <= ccy + 1'b1;
          end else begin
            ccx <= ccx + 1'b1;
          end
        end
      end
      d_vld <= c_vld;
      e_vld <= d_vld;
      r1_we <= e_vld ? 4'hF : 4'h0;
      if (e_vld) begin
        r1_addr <= out_cnt << 2;
        r1_din  <= 32'(e_res);
        out_cnt <= out_cnt + 32'd1;
        last_wr <= (out_cnt == LAST_IDX);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (b_vld) begin
      lb1[xi] <= lb0[xi];
      lb0[xi] <= in_px;
      win[0] <= win[1]; win[1] <= win[2]; win[2] <= lb1[xi];
      win[3] <= win[4]; win[4] <= win[5]; win[5] <= lb0[xi];
      win[6] <= win[7]; win[7] <= win[8]; win[8] <= in_px;
    end
    d_gx <= gx;
    d_gy <= gy;
    for (int i = 0; i < 9; i++) d_prod[i] <= prod[i];
    e_res <= res;
  end

  // Border masking replaces both the stale line-buffer rows and horizontal wrap.
  always_comb begin
    for (int i = 0; i < 9; i++) m[i] = win[i];
    if (c_x == '0)    begin m[0] = '0; m[3] = '0; m[6] = '0; end
    if (c_x == X_LAST) begin m[2] = '0; m[5] = '0; m[8] = '0; end
    if (c_y == '0)    begin m[0] = '0; m[1] = '0; m[2] = '0; end
    if (c_y == Y_LAST) begin m[6] = '0; m[7] = '0; m[8] = '0; end
    for (int i = 0; i < 9; i++) begin
      pz[i]   = ACC_W'(m[i]);
      prod[i] = pz[i] * ACC_W'(kern[i]);
    end
    gx = pz[0] - pz[2] + (pz[3] <<< 1) - (pz[5] <<< 1) + pz[6] - pz[8];
    gy = pz[0] + (pz[1] <<< 1) + pz[2] - pz[6] - (pz[7] <<< 1) - pz[8];
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < 9; i++) sum = sum + d_prod[i];
    t  = sum >>> shift_q;
    ax = (d_gx < 0) ? -d_gx : d_gx;
    ay = (d_gy < 0) ? -d_gy : d_gy;
    case (mode_q)
      2'd1:    mag = (t < 0) ? '0 : t;
      2'd2:    mag = (t < 0) ? -t : t;
      default: mag = ax + ay;
    endcase
    res = (mag > PMAX) ? PIX_W'(PMAX) : PIX_W'(mag);
  end
endmodule
